// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, default widths and occupancy width helper for the FIFO read side
package fifo_pkg;

  localparam int DEFAULT_BITNUMBER = 8;
  localparam int DEFAULT_LENGTH    = 8;

  // Occupancy must represent 0..LENGTH inclusive, hence the extra bit.
  function automatic int cw_of(input int length);
    return $clog2(length) + 1;
  endfunction

  localparam int CW = cw_of(DEFAULT_LENGTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_lector_if.sv
// rtl/fifo_lector_if.sv - FIFO-side, downstream and flow-control signals of the read controller
interface fifo_lector_if
  import fifo_pkg::*;
#(
  parameter int BITNUMBER = DEFAULT_BITNUMBER,
  parameter int LENGTH    = DEFAULT_LENGTH
);
  localparam int IF_CW = cw_of(LENGTH);

  logic                 Fifo_empty;
  logic [IF_CW-1:0]     Fifo_count;
  logic [BITNUMBER-1:0] Fifo_Data_out;
  logic                 Fifo_rd;
  logic                 rd_en;
  logic [2:0]           Umbral_alto;
  logic [2:0]           Umbral_bajo;
  logic                 out_ready;
  logic                 valid_out;
  logic [BITNUMBER-1:0] data_out;
  logic                 pause;
  logic [15:0]          words_out;

  modport master (
    input  Fifo_empty, Fifo_count, Fifo_Data_out, rd_en,
           Umbral_alto, Umbral_bajo, out_ready,
    output Fifo_rd, valid_out, data_out, pause, words_out
  );

  modport slave (
    output Fifo_empty, Fifo_count, Fifo_Data_out, rd_en,
           Umbral_alto, Umbral_bajo, out_ready,
    input  Fifo_rd, valid_out, data_out, pause, words_out
  );

endinterface

// File: rtl/fifo_lector_skid_buffer2.sv
// rtl/fifo_lector_skid_buffer2.sv - two-entry circular skid buffer absorbing the FIFO read latency
module skid_buffer2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] data,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         head;
  logic         wr_idx;
  logic         push_ok;
  logic         pop_ok;

  // Tail sits one slot past head when a single word is held.
  assign wr_idx  = head ^ occ[0];
  assign push_ok = push & (occ != 2'd2);
  assign pop_ok  = pop & (occ != 2'd0);
  assign data    = mem[head];

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push_ok) mem[wr_idx] <= push_data;
      if (pop_ok)  head <= ~head;
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_lector.sv
// rtl/fifo_lector.sv - FIFO read controller with skid buffer, pause hysteresis and delivered-word counter
module fifo_lector
  import fifo_pkg::*;
#(
  parameter int BITNUMBER = DEFAULT_BITNUMBER,
  parameter int LENGTH    = DEFAULT_LENGTH
) (
  input  logic           clk,
  input  logic           reset,
  fifo_lector_if.master  bus
);

  localparam int LCW = cw_of(LENGTH);

  state_t               state;
  state_t               state_nx;
  logic [1:0]           occ;
  logic                 inflight;
  logic                 pop;
  logic                 fifo_rd;
  logic [2:0]           pend;
  logic [2:0]           limit;
  logic [BITNUMBER-1:0] head_data;
  logic                 pause_r;
  logic [15:0]          words_r;
  logic [LCW-1:0]       alto;
  logic [LCW-1:0]       bajo;

  assign pop   = (occ != 2'd0) & bus.out_ready;
  assign pend  = {1'b0, occ} + {2'b0, inflight};
  // Credit check: words held plus words in flight, less the one leaving now, must fit in 2.
  assign limit = 3'd1 + {2'b0, pop};
  assign fifo_rd = (state == ACTIVE) & ~bus.Fifo_empty & (pend <= limit);

  assign bus.Fifo_rd   = fifo_rd;
  assign bus.valid_out = (occ != 2'd0);
  assign bus.data_out  = head_data;
  assign bus.pause     = pause_r;
  assign bus.words_out = words_r;

  skid_buffer2 #(.W(BITNUMBER)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (bus.Fifo_Data_out),
    .pop       (pop),
    .data      (head_data),
    .occ       (occ)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      inflight <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= fifo_rd;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (bus.rd_en) state_nx = ACTIVE;
      ACTIVE: if (!bus.rd_en) state_nx = (inflight || occ != 2'd0) ? DRAIN : IDLE;
      DRAIN: begin
        if (bus.rd_en)                        state_nx = ACTIVE;
        else if (!inflight && occ == 2'd0)    state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign alto = LCW'(bus.Umbral_alto);
  assign bajo = LCW'(bus.Umbral_bajo);

  // Inverted or equal thresholds collapse to a plain comparator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pause_r <= 1'b0;
    end else if (alto <= bajo) begin
      pause_r <= (bus.Fifo_count >= alto);
    end else if (bus.Fifo_count >= alto) begin
      pause_r <= 1'b1;
    end else if (bus.Fifo_count <= bajo) begin
      pause_r <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) words_r <= 16'd0;
    else if (pop) words_r <= words_r + 16'd1;
  end

endmodule

// File: tb/tb_fifo_lector.sv
// tb/tb_fifo_lector.sv - directed self-checking bench for the FIFO read controller
module tb_fifo_lector;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_lector_if #(.BITNUMBER(8), .LENGTH(8)) bus ();

  fifo_lector #(.BITNUMBER(8), .LENGTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural FIFO with one-cycle read latency
  logic [7:0] mem [64];
  int         rptr = 0;
  int         wptr = 0;
  logic [7:0] fdata = 8'h00;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_cnt = 4'd0;

  always @(posedge clk) begin
    if (flush) begin
      rptr <= 0;
      wptr <= 0;
    end else begin
      if (wr_en) begin
        mem[wptr % 64] <= wr_data;
        wptr <= wptr + 1;
      end
      if (bus.Fifo_rd) begin
        fdata <= mem[rptr % 64];
        rptr <= rptr + 1;
      end
    end
  end

  assign bus.Fifo_empty    = (wptr == rptr);
  assign bus.Fifo_count    = ovr_en ? ovr_cnt : 4'(wptr - rptr);
  assign bus.Fifo_Data_out = fdata;

  int         rd_cnt = 0;
  logic       bulk = 1'b0;
  logic [7:0] rcv [$];

  always @(posedge clk) begin
    if (reset && bus.Fifo_rd) rd_cnt <= rd_cnt + 1;
    if (reset && bus.valid_out && bus.out_ready && !bulk) rcv.push_back(bus.data_out);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] v);
    wr_data = v;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.rd_en = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) load_word(8'(i));
    tick();
    tick();
    checks++; if (bus.Fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_fifo_rd got=%b exp=0", bus.Fifo_rd); end
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
    checks++; if (bus.pause !== 1'b0) begin failures++; $display("FAIL reset_pause got=%b exp=0", bus.pause); end
    checks++; if (bus.words_out !== 16'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", bus.words_out); end
    checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.data_out); end
    bus.rd_en = 1'b0;
    do_flush();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_streaming;
    logic       exp_rd [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_v  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_d  [8] = '{8'h00, 8'h00, 8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00};
    load_word(8'h0A);
    load_word(8'h0B);
    load_word(8'h0C);
    load_word(8'h0D);
    bus.out_ready = 1'b1;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.Fifo_rd !== exp_rd[i]) begin failures++; $display("FAIL stream_rd[%0d] got=%b exp=%b", i, bus.Fifo_rd, exp_rd[i]); end
      checks++;
      if (bus.valid_out !== exp_v[i]) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=%b", i, bus.valid_out, exp_v[i]); end
      if (exp_v[i]) begin
        checks++;
        if (bus.data_out !== exp_d[i]) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, bus.data_out, exp_d[i]); end
      end
      tick();
    end
    checks++; if (bus.words_out !== 16'd4) begin failures++; $display("FAIL stream_words got=%0d exp=4", bus.words_out); end
    bus.rd_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_backpressure;
    int         r0;
    logic       hold;
    logic [7:0] held;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) load_word(8'h11 + 8'(i));
    r0 = rd_cnt;
    rcv.delete();
    bus.rd_en = 1'b1;
    repeat (8) tick();
    checks++; if (rd_cnt - r0 != 2) begin failures++; $display("FAIL bp_reads got=%0d exp=2", rd_cnt - r0); end
    checks++; if (dut.occ !== 2'd2) begin failures++; $display("FAIL bp_occ got=%0d exp=2", dut.occ); end
    checks++; if (bus.data_out !== 8'h11) begin failures++; $display("FAIL bp_head got=%h exp=11", bus.data_out); end
    hold = 1'b0;
    held = 8'h00;
    for (int i = 0; i < 60 && rcv.size() < 6; i++) begin
      if (hold) begin
        checks++;
        if (bus.data_out !== held) begin failures++; $display("FAIL bp_stable got=%h exp=%h", bus.data_out, held); end
      end
      bus.out_ready = (i % 2 == 0);
      hold = bus.valid_out & ~bus.out_ready;
      held = bus.data_out;
      tick();
    end
    bus.out_ready = 1'b0;
    bus.rd_en = 1'b0;
    repeat (3) tick();
    checks++; if (rcv.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", rcv.size()); end
    for (int i = 0; i < rcv.size() && i < 6; i++) begin
      checks++;
      if (rcv[i] !== 8'h11 + 8'(i)) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, rcv[i], 8'h11 + 8'(i)); end
    end
    checks++; if (rd_cnt - r0 != 6) begin failures++; $display("FAIL bp_total_reads got=%0d exp=6", rd_cnt - r0); end
    checks++; if (bus.words_out !== 16'd10) begin failures++; $display("FAIL bp_words got=%0d exp=10", bus.words_out); end
  endtask

  task automatic test_hysteresis;
    logic [3:0] cnts  [15] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                               4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    logic       exp_p [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.Umbral_alto = 3'd6;
    bus.Umbral_bajo = 3'd2;
    ovr_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ovr_cnt = cnts[i];
      tick();
      checks++;
      if (bus.pause !== exp_p[i]) begin failures++; $display("FAIL hyst[%0d] cnt=%0d got=%b exp=%b", i, cnts[i], bus.pause, exp_p[i]); end
    end
    bus.Umbral_alto = 3'd3;
    bus.Umbral_bajo = 3'd5;
    ovr_cnt = 4'd4;
    tick();
    checks++; if (bus.pause !== 1'b1) begin failures++; $display("FAIL nohyst_hi got=%b exp=1", bus.pause); end
    ovr_cnt = 4'd2;
    tick();
    checks++; if (bus.pause !== 1'b0) begin failures++; $display("FAIL nohyst_lo got=%b exp=0", bus.pause); end
    ovr_en = 1'b0;
    bus.Umbral_alto = 3'd7;
    bus.Umbral_bajo = 3'd0;
    tick();
  endtask

  task automatic test_drain;
    int r0;
    int n0;
    int i;
    bus.out_ready = 1'b0;
    bus.rd_en = 1'b0;
    for (int k = 0; k < 4; k++) load_word(8'h31 + 8'(k));
    r0 = rd_cnt;
    n0 = rcv.size();
    bus.rd_en = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (dut.occ !== 2'd1 || dut.inflight !== 1'b1) begin failures++; $display("FAIL drain_setup occ=%0d inflight=%b exp=1/1", dut.occ, dut.inflight); end
    bus.rd_en = 1'b0;
    tick();
    checks++; if (dut.state !== DRAIN) begin failures++; $display("FAIL drain_state got=%0d exp=%0d", dut.state, DRAIN); end
    bus.out_ready = 1'b1;
    for (i = 0; i < 20 && dut.state != IDLE; i++) tick();
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL drain_idle got=%0d exp=%0d", dut.state, IDLE); end
    checks++; if (rcv.size() - n0 != 2) begin failures++; $display("FAIL drain_words got=%0d exp=2", rcv.size() - n0); end
    checks++; if (rd_cnt - r0 != 2) begin failures++; $display("FAIL drain_reads got=%0d exp=2", rd_cnt - r0); end
    if (rcv.size() >= n0 + 2) begin
      checks++;
      if (rcv[n0] !== 8'h31 || rcv[n0+1] !== 8'h32) begin failures++; $display("FAIL drain_data got=%h,%h exp=31,32", rcv[n0], rcv[n0+1]); end
    end
    do_flush();
  endtask

  task automatic test_empty;
    int r0;
    r0 = rd_cnt;
    bus.rd_en = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    checks++; if (rd_cnt != r0) begin failures++; $display("FAIL empty_reads got=%0d exp=0", rd_cnt - r0); end
    bus.rd_en = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_mid_reset;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) load_word(8'h41 + 8'(k));
    bus.rd_en = 1'b1;
    repeat (5) tick();
    checks++; if (dut.occ !== 2'd2) begin failures++; $display("FAIL mid_occ got=%0d exp=2", dut.occ); end
    reset = 1'b0;
    bus.rd_en = 1'b0;
    tick();
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.valid_out); end
    checks++; if (bus.words_out !== 16'd0) begin failures++; $display("FAIL mid_words got=%0d exp=0", bus.words_out); end
    checks++; if (dut.inflight !== 1'b0 || dut.occ !== 2'd0) begin failures++; $display("FAIL mid_state inflight=%b occ=%0d exp=0/0", dut.inflight, dut.occ); end
    do_flush();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_wrap;
    int i;
    bulk = 1'b1;
    bus.rd_en = 1'b1;
    bus.out_ready = 1'b1;
    wr_data = 8'h5A;
    wr_en = 1'b1;
    repeat (65535) tick();
    wr_en = 1'b0;
    for (i = 0; i < 50 && bus.words_out != 16'hFFFF; i++) tick();
    repeat (3) tick();
    checks++; if (bus.words_out !== 16'hFFFF) begin failures++; $display("FAIL wrap_preset got=%0d exp=65535", bus.words_out); end
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL wrap_idle_valid got=%b exp=0", bus.valid_out); end
    load_word(8'h77);
    for (i = 0; i < 10 && bus.words_out == 16'hFFFF; i++) tick();
    checks++; if (bus.words_out !== 16'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", bus.words_out); end
    bus.rd_en = 1'b0;
    bulk = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.rd_en = 1'b0;
    bus.out_ready = 1'b0;
    bus.Umbral_alto = 3'd7;
    bus.Umbral_bajo = 3'd0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_hysteresis();
    test_drain();
    test_empty();
    test_mid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
